// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types and constants.
// Used by the ID/EX boundary and its hazard logic.
package riscv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 9;
  localparam int BUB_W  = 16;

  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_ALU_OP_HI  = 2;
  localparam int CTRL_ALU_OP_LO  = 1;
  localparam int CTRL_JUMP       = 0;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ITYPE  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        funct;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  function automatic logic ctrl_mem_read(
    input logic [CTRL_W-1:0] c
  );
    return c[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX boundary.
// master drives the ID side; slave is the stage itself.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rdata1;
  logic [XLEN-1:0]   id_rdata2;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [3:0]        id_funct;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_flush;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rdata1;
  logic [XLEN-1:0]   ex_rdata2;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic [3:0]        ex_funct;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall;
  logic [BUB_W-1:0]  bubble_count;

  modport master (
    output id_valid, id_pc, id_rdata1, id_rdata2,
    output id_imm, id_rs1, id_rs2, id_rd, id_funct,
    output id_rs1_used, id_rs2_used, id_ctrl, ex_flush,
    input  ex_valid, ex_pc, ex_rdata1, ex_rdata2,
    input  ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
    input  ex_ctrl, stall, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rdata1, id_rdata2,
    input  id_imm, id_rs1, id_rs2, id_rd, id_funct,
    input  id_rs1_used, id_rs2_used, id_ctrl, ex_flush,
    output ex_valid, ex_pc, ex_rdata1, ex_rdata2,
    output ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct,
    output ex_ctrl, stall, bubble_count
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose rd is
// read by the ID instruction forces a one-cycle stall.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic              id_rs1_used_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs2_used_i,
  output logic              stall_o
);

  logic load_in_ex;
  logic hit1;
  logic hit2;

  // x0 is never written, so a load to it cannot feed anyone
  assign load_in_ex = ex_valid_i && ex_mem_read_i
                   && (ex_rd_i != '0);
  assign hit1 = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign hit2 = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign stall_o = load_in_ex && id_valid_i
                && (hit1 || hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection
// and a saturating bubble counter.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  localparam logic [BUB_W-1:0] BUB_MAX = '1;

  id_ex_t           ex_q, ex_d, id_in;
  logic             valid_q, valid_d;
  logic [BUB_W-1:0] bubble_q, bubble_d;
  logic             stall;

  load_use_detect u_lud (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_mem_read(ex_q.ctrl)),
    .ex_rd_i       (ex_q.rd),
    .id_valid_i    (bus.id_valid),
    .id_rs1_i      (bus.id_rs1),
    .id_rs1_used_i (bus.id_rs1_used),
    .id_rs2_i      (bus.id_rs2),
    .id_rs2_used_i (bus.id_rs2_used),
    .stall_o       (stall)
  );

  always_comb begin
    id_in.pc     = bus.id_pc;
    id_in.rdata1 = bus.id_rdata1;
    id_in.rdata2 = bus.id_rdata2;
    id_in.imm    = bus.id_imm;
    id_in.rs1    = bus.id_rs1;
    id_in.rs2    = bus.id_rs2;
    id_in.rd     = bus.id_rd;
    id_in.funct  = bus.id_funct;
    id_in.ctrl   = bus.id_valid ? bus.id_ctrl : '0;
  end

  // flush outranks stall; data fields hold on a kill
  always_comb begin
    ex_d     = ex_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;
    if (bus.ex_flush) begin
      valid_d = 1'b0;
      ex_d.ctrl = '0;
    end else if (stall) begin
      valid_d = 1'b0;
      ex_d.ctrl = '0;
      if (bubble_q != BUB_MAX)
        bubble_d = bubble_q + 1'b1;
    end else begin
      ex_d    = id_in;
      valid_d = bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      ex_q     <= ex_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rdata1    = ex_q.rdata1;
  assign bus.ex_rdata2    = ex_q.rdata2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_funct     = ex_q.funct;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.stall        = stall;
  assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, random traffic
// against a reference model, and counter saturation.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam logic [8:0] C_ALU = 9'h104;
  localparam logic [8:0] C_LD  = 9'h1B0;
  localparam logic [8:0] C_IMM = 9'h110;

  typedef struct {
    logic        rst;
    logic        v;
    logic [63:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [3:0]  fn;
    logic [8:0]  ctrl;
    logic        fl;
  } in_t;

  typedef struct {
    in_t         in;
    logic        e_stall;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [63:0] e_r1;
    logic [8:0]  e_ctrl;
    logic [15:0] e_bub;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  in_t  m_ex;
  logic m_valid;
  int   m_total;
  logic last_stall;
  vec_t tbl[21];

  function automatic in_t zero_in();
    in_t x;
    x.rst = 0; x.v = 0; x.pc = 0; x.r1 = 0;
    x.r2 = 0; x.imm = 0; x.rs1 = 0; x.rs2 = 0;
    x.rd = 0; x.u1 = 0; x.u2 = 0; x.fn = 0;
    x.ctrl = 0; x.fl = 0;
    return x;
  endfunction

  function automatic in_t ins(
    input logic v,
    input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2,
    input logic [4:0] rd,
    input logic [8:0] ctrl,
    input logic [63:0] r1
  );
    in_t x = zero_in();
    x.v = v; x.rs1 = rs1; x.u1 = u1;
    x.rs2 = rs2; x.u2 = u2; x.rd = rd;
    x.ctrl = ctrl; x.r1 = r1;
    x.r2 = r1 + 64'd2;
    x.pc = 64'h1000 + (r1 << 2);
    x.imm = ~r1;
    x.fn = r1[3:0];
    return x;
  endfunction

  function automatic in_t rs(input in_t x);
    in_t y = x;
    y.rst = 1;
    return y;
  endfunction

  function automatic in_t fl(input in_t x);
    in_t y = x;
    y.fl = 1;
    return y;
  endfunction

  function automatic vec_t row(
    input in_t x, input logic st, input logic va,
    input logic [4:0] rd, input logic [63:0] r1,
    input logic [8:0] c, input logic [15:0] b
  );
    vec_t r;
    r.in = x; r.e_stall = st; r.e_valid = va;
    r.e_rd = rd; r.e_r1 = r1; r.e_ctrl = c;
    r.e_bub = b;
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // a load sitting in EX whose rd the ID instruction reads
  function automatic logic ref_hazard(input in_t x);
    logic reads;
    reads = (x.u1 && x.rs1 == m_ex.rd)
         || (x.u2 && x.rs2 == m_ex.rd);
    return m_valid && m_ex.ctrl[CTRL_MEM_READ]
        && m_ex.rd != 0 && x.v && reads;
  endfunction

  function automatic logic [15:0] ref_bub();
    if (m_total > 65535) return 16'hFFFF;
    return m_total[15:0];
  endfunction

  task automatic step(input in_t x);
    logic hz;
    @(negedge clk);
    reset           = x.rst;
    bus.id_valid    = x.v;
    bus.id_pc       = x.pc;
    bus.id_rdata1   = x.r1;
    bus.id_rdata2   = x.r2;
    bus.id_imm      = x.imm;
    bus.id_rs1      = x.rs1;
    bus.id_rs2      = x.rs2;
    bus.id_rd       = x.rd;
    bus.id_funct    = x.fn;
    bus.id_rs1_used = x.u1;
    bus.id_rs2_used = x.u2;
    bus.id_ctrl     = x.ctrl;
    bus.ex_flush    = x.fl;
    #1;
    hz = ref_hazard(x);
    last_stall = bus.stall;
    chk("stall", bus.stall, hz);
    if (x.rst) begin
      m_ex = zero_in(); m_valid = 0; m_total = 0;
    end else if (x.fl) begin
      m_valid = 0; m_ex.ctrl = 0;
    end else if (hz) begin
      m_valid = 0; m_ex.ctrl = 0; m_total++;
    end else begin
      m_ex = x; m_valid = x.v;
      if (!x.v) m_ex.ctrl = 0;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_ctrl", bus.ex_ctrl, m_ex.ctrl);
    chk("ex_pc", bus.ex_pc, m_ex.pc);
    chk("ex_rdata1", bus.ex_rdata1, m_ex.r1);
    chk("ex_rdata2", bus.ex_rdata2, m_ex.r2);
    chk("ex_imm", bus.ex_imm, m_ex.imm);
    chk("ex_rs1", bus.ex_rs1, m_ex.rs1);
    chk("ex_rs2", bus.ex_rs2, m_ex.rs2);
    chk("ex_rd", bus.ex_rd, m_ex.rd);
    chk("ex_funct", bus.ex_funct, m_ex.fn);
    chk("bubbles", bus.bubble_count, ref_bub());
  endtask

  function automatic in_t rnd_in();
    in_t x;
    x.rst  = ($urandom_range(0, 99) == 0);
    x.v    = ($urandom_range(0, 9) != 0);
    x.pc   = {$urandom, $urandom};
    x.r1   = {$urandom, $urandom};
    x.r2   = {$urandom, $urandom};
    x.imm  = {$urandom, $urandom};
    x.rs1  = 5'($urandom_range(0, 3));
    x.rs2  = 5'($urandom_range(0, 3));
    x.rd   = 5'($urandom_range(0, 3));
    x.u1   = 1'($urandom_range(0, 1));
    x.u2   = 1'($urandom_range(0, 1));
    x.fn   = 4'($urandom_range(0, 15));
    x.ctrl = 9'($urandom);
    x.fl   = ($urandom_range(0, 19) == 0);
    return x;
  endfunction

  initial begin
    in_t idle;
    in_t use6;
    m_ex = zero_in(); m_valid = 0; m_total = 0;
    idle = zero_in();
    tbl[0]  = row(rs(idle), 0, 0, 0, 0, 0, 0);
    tbl[1]  = row(rs(idle), 0, 0, 0, 0, 0, 0);
    tbl[2]  = row(ins(1, 1, 1, 2, 1, 3, C_ALU, 5),
                  0, 1, 3, 5, C_ALU, 0);
    tbl[3]  = row(ins(1, 2, 1, 0, 0, 6, C_LD, 100),
                  0, 1, 6, 100, C_LD, 0);
    tbl[4]  = row(ins(1, 6, 1, 7, 1, 8, C_ALU, 11),
                  1, 0, 6, 100, 0, 1);
    tbl[5]  = row(ins(1, 6, 1, 7, 1, 8, C_ALU, 11),
                  0, 1, 8, 11, C_ALU, 1);
    tbl[6]  = row(ins(1, 1, 1, 0, 0, 0, C_LD, 20),
                  0, 1, 0, 20, C_LD, 1);
    tbl[7]  = row(ins(1, 0, 1, 0, 0, 5, C_ALU, 21),
                  0, 1, 5, 21, C_ALU, 1);
    tbl[8]  = row(ins(1, 1, 1, 0, 0, 9, C_LD, 30),
                  0, 1, 9, 30, C_LD, 1);
    tbl[9]  = row(ins(1, 3, 1, 9, 0, 10, C_IMM, 31),
                  0, 1, 10, 31, C_IMM, 1);
    tbl[10] = row(ins(1, 1, 1, 0, 0, 12, C_LD, 40),
                  0, 1, 12, 40, C_LD, 1);
    tbl[11] = row(ins(1, 12, 1, 0, 0, 13, C_LD, 41),
                  1, 0, 12, 40, 0, 2);
    tbl[12] = row(ins(1, 12, 1, 0, 0, 13, C_LD, 41),
                  0, 1, 13, 41, C_LD, 2);
    tbl[13] = row(ins(1, 1, 1, 13, 1, 14, C_ALU, 42),
                  1, 0, 13, 41, 0, 3);
    tbl[14] = row(ins(1, 1, 1, 13, 1, 14, C_ALU, 42),
                  0, 1, 14, 42, C_ALU, 3);
    tbl[15] = row(ins(1, 1, 1, 0, 0, 4, C_LD, 50),
                  0, 1, 4, 50, C_LD, 3);
    tbl[16] = row(fl(ins(1, 4, 1, 0, 0, 15, C_ALU, 51)),
                  1, 0, 4, 50, 0, 3);
    tbl[17] = row(ins(0, 0, 0, 0, 0, 16, C_ALU, 60),
                  0, 0, 16, 60, 0, 3);
    tbl[18] = row(ins(1, 1, 1, 0, 0, 5, C_LD, 70),
                  0, 1, 5, 70, C_LD, 3);
    tbl[19] = row(rs(ins(1, 5, 1, 0, 0, 17, C_ALU, 71)),
                  1, 0, 0, 0, 0, 0);
    tbl[20] = row(ins(1, 5, 1, 0, 0, 17, C_ALU, 71),
                  0, 1, 17, 71, C_ALU, 0);

    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("row%0d_stall", i),
          last_stall, tbl[i].e_stall);
      chk($sformatf("row%0d_valid", i),
          bus.ex_valid, tbl[i].e_valid);
      chk($sformatf("row%0d_rd", i),
          bus.ex_rd, tbl[i].e_rd);
      chk($sformatf("row%0d_rdata1", i),
          bus.ex_rdata1, tbl[i].e_r1);
      chk($sformatf("row%0d_ctrl", i),
          bus.ex_ctrl, tbl[i].e_ctrl);
      chk($sformatf("row%0d_bub", i),
          bus.bubble_count, tbl[i].e_bub);
    end

    for (int k = 0; k < 600; k++)
      step(rnd_in());

    // preload the counter near the top instead of
    // spending ~131k cycles on real bubbles
    step(ins(1, 1, 1, 0, 0, 6, C_LD, 80));
    force dut.bubble_q = 16'hFFFC;
    #1;
    release dut.bubble_q;
    m_total = 65532;
    for (int k = 0; k < 14; k++) begin
      use6 = ins(1, 6, 1, 0, 0, 6, C_LD, 64'(81 + k));
      step(use6);
    end
    chk("saturated", bus.bubble_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 64-bit RISC-V datapath. Sits directly downstream of the register file.
- Each cycle it captures ReadData1/ReadData2, the immediate, register indices and decoded control signals into EX-stage registers.
- It also contains the load-use hazard detector. When the detector fires, it holds IF/ID and injects a bubble into EX.
- Branch-taken flush from EX clears the stage.

Parameters:
- XLEN, 64, datapath width (operands, immediate, PC).
- REG_AW, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_pc  input  XLEN  PC of the ID instruction.
- id_rdata1  input  XLEN  register file ReadData1.
- id_rdata2  input  XLEN  register file ReadData2.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1  input  REG_AW  source index 1.
- id_rs2  input  REG_AW  source index 2.
- id_rd  input  REG_AW  destination index.
- id_funct  input  4  {instr[30], instr[14:12]}.
- id_rs1_used  input  1  instruction reads rs1.
- id_rs2_used  input  1  instruction reads rs2.
- id_ctrl  input  9  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0], jump}.
- ex_flush  input  1  branch/jump taken in EX; kill the ID instruction.
- ex_valid  output  1  EX holds a real instruction.
- ex_pc  output  XLEN  registered id_pc.
- ex_rdata1  output  XLEN  registered id_rdata1.
- ex_rdata2  output  XLEN  registered id_rdata2.
- ex_imm  output  XLEN  registered id_imm.
- ex_rs1  output  REG_AW  registered id_rs1.
- ex_rs2  output  REG_AW  registered id_rs2.
- ex_rd  output  REG_AW  registered id_rd.
- ex_funct  output  4  registered id_funct.
- ex_ctrl  output  9  registered id_ctrl.
- stall  output  1  hold PC and IF/ID this cycle (combinational).
- bubble_count  output  16  saturating count of injected load-use bubbles.

Behaviour:
- Reset (synchronous, active-high), all outputs zero:
  - ex_valid=0, ex_ctrl=0, all data/index/funct fields 0, bubble_count=0.
  - stall reads 0 because ex_valid=0.
- Hazard detect (combinational, same cycle), stall=1 iff all of:
  - ex_valid && ex_ctrl.mem_read && ex_rd!=0 && id_valid;
  - and either (id_rs1_used && id_rs1==ex_rd) or (id_rs2_used && id_rs2==ex_rd).
- Register update each rising edge, priority highest first:
  1. reset: as above.
  2. ex_flush: ex_valid<=0, ex_ctrl<=0. Data fields are don't-care but held. stall has no effect. bubble_count unchanged.
  3. stall: bubble. ex_valid<=0, ex_ctrl<=0. bubble_count increments, saturating at 0xFFFF.
  4. otherwise: all ex_* <= id_* ; ex_valid<=id_valid.
     - If id_valid=0, ex_ctrl<=0 so no side-effects leak into EX.
- Latency: exactly 1 cycle ID->EX.
- A load-use pair costs exactly one bubble. On the next cycle the load has left EX, so stall deasserts and the consumer advances.
- Loads to x0 never stall.
- Two back-to-back loads where the second uses the first's rd: the second load stalls once. Its own consumer then stalls once more.
- ex_flush and stall together: the flush wins. ex_flush is also forwarded upstream by the parent, so the held IF/ID instruction is killed there.
- Reset asserted mid-stall: reset wins. stall drops on the following cycle.
- No forwarding muxing is done here. ex_rs1/ex_rs2 are exported so the forwarding unit can use them.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, REG_AW.
  - Control-bundle bit positions (CTRL_REG_WRITE ... CTRL_JUMP).
  - CTRL_W=9.
  - The ALU_OP encodings.
- One natural sub-module: load_use_detect, purely combinational. It produces stall from ex_valid, ex_mem_read, ex_rd, id_valid, id_rs1/rs2 and their used flags. It is reused later by the stage-accurate reference model.

Test Plan:
- Pass-through: reset for 2 cycles, then id_valid=1, id_rdata1=5, id_rdata2=7, id_rd=3, ctrl=reg_write|alu_op=2'b10 -> next cycle ex_rdata1=5, ex_rdata2=7, ex_rd=3, ex_valid=1, stall=0.
- Load-use: cycle N load (mem_read=1, rd=6) in EX; ID add with rs1=6 -> stall=1 in N. At N+1: ex_valid=0, ex_ctrl=0, bubble_count=1. At N+1 the add is presented again -> stall=0, and the add is in EX at N+2.
- x0/unused: load rd=0 with rs1=0 -> stall=0. Load rd=9 with id_rs2=9 but id_rs2_used=0 (I-type) -> stall=0.
- Flush priority: load rd=4 in EX, ID rs1=4, ex_flush=1 same cycle -> next cycle ex_valid=0, bubble_count unchanged.
- Reset mid-stall: stall=1 and reset=1 same edge -> all ex_* = 0, bubble_count=0, stall=0 next cycle.
- Saturation: force 65,540 load-use pairs -> bubble_count stays 0xFFFF.
